// File: rtl/ps2_defs.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// frame geometry and common keyboard command bytes.
package ps2_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int ACK_EDGE  = 11;
  localparam int STOP_EDGE = ACK_EDGE - 1;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the open-collector PS/2 clock and data lines into the system clock
// domain and flags falling edges of the device clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_sclk,
  input  logic ps2_data,
  output logic sclk_sync,
  output logic data_sync,
  output logic sclk_fall
);

  logic [1:0] sclk_meta;
  logic [1:0] data_meta;
  logic       sclk_prev;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_meta <= 2'b11;
      data_meta <= 2'b11;
      sclk_prev <= 1'b1;
    end else begin
      sclk_meta <= {sclk_meta[0], ps2_sclk};
      data_meta <= {data_meta[0], ps2_data};
      sclk_prev <= sclk_meta[1];
    end
  end

  assign sclk_sync = sclk_meta[1];
  assign data_sync = data_meta[1];
  assign sclk_fall = sclk_prev & ~sclk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibits the bus, issues a request-to-send, shifts a
// command byte out on device clock edges and checks the device ACK.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_sclk,
  input  logic       i_ps2_data,
  output logic       o_ps2_sclk_oe,
  output logic       o_ps2_data_oe,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_err
);

  localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] START_LAST   = 32'(START_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_SHIFT   = 4'(STOP_EDGE - 1);

  state_t               state_q, state_next;
  logic                 sclk_sync, data_sync, sclk_fall;
  logic [31:0]          phase_cnt, to_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS:0]   frame_q;
  logic                 idle_hi_q;
  logic                 accept, bus_phase, timeout;
  logic                 sclk_oe_d, data_oe_d, done_d, err_d, ready_d, busy_d;

  ps2_line_sync u_sync (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .ps2_sclk  (i_ps2_sclk),
    .ps2_data  (i_ps2_data),
    .sclk_sync (sclk_sync),
    .data_sync (data_sync),
    .sclk_fall (sclk_fall)
  );

  assign accept    = i_tx_valid && o_tx_ready;
  assign bus_phase = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout   = bus_phase && !sclk_fall && (to_cnt == TIMEOUT_LAST);

  // Outputs are registered alongside the state so they line up with it exactly.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      o_ps2_sclk_oe <= 1'b0;
      o_ps2_data_oe <= 1'b0;
      o_tx_done     <= 1'b0;
      o_tx_err      <= 1'b0;
      o_tx_ready    <= 1'b1;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_next;
      o_ps2_sclk_oe <= sclk_oe_d;
      o_ps2_data_oe <= data_oe_d;
      o_tx_done     <= done_d;
      o_tx_err      <= err_d;
      o_tx_ready    <= ready_d;
      o_busy        <= busy_d;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_next = ST_INHIBIT;
      ST_INHIBIT:   if (phase_cnt == INHIBIT_LAST) state_next = ST_START;
      ST_START:     if (phase_cnt == START_LAST) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (timeout) state_next = ST_IDLE;
        else if (sclk_fall && bit_cnt == LAST_SHIFT) state_next = ST_ACK;
      end
      ST_ACK: begin
        if (timeout) state_next = ST_IDLE;
        else if (sclk_fall) state_next = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (timeout) state_next = ST_IDLE;
        else if (sclk_sync && data_sync && idle_hi_q) state_next = ST_IDLE;
      end
      default:      state_next = ST_IDLE;
    endcase
  end

  // The data line stays low from START into SHIFT as the start bit, then
  // follows the frame after each device falling edge; edge 10 releases it.
  always_comb begin
    sclk_oe_d = (state_next == ST_INHIBIT) || (state_next == ST_START);
    data_oe_d = 1'b0;
    if (state_next == ST_START) begin
      data_oe_d = 1'b1;
    end else if (state_next == ST_SHIFT) begin
      if (state_q != ST_SHIFT) data_oe_d = 1'b1;
      else if (sclk_fall)      data_oe_d = ~frame_q[0];
      else                     data_oe_d = o_ps2_data_oe;
    end
    done_d  = (state_q == ST_ACK) && sclk_fall && !data_sync;
    err_d   = timeout || ((state_q == ST_ACK) && sclk_fall && data_sync);
    ready_d = (state_next == ST_IDLE);
    busy_d  = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase_cnt <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      frame_q   <= '0;
      idle_hi_q <= 1'b0;
    end else begin
      if (state_next != state_q)
        phase_cnt <= '0;
      else if (state_q == ST_INHIBIT || state_q == ST_START)
        phase_cnt <= phase_cnt + 32'd1;

      if (!bus_phase || sclk_fall) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 32'd1;

      if (accept) begin
        frame_q <= {odd_parity(i_tx_data), i_tx_data};
        bit_cnt <= '0;
      end else if (state_q == ST_SHIFT && sclk_fall) begin
        frame_q <= {1'b1, frame_q[DATA_BITS:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end

      idle_hi_q <= sclk_sync & data_sync;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;
  import ps2_defs::*;

  localparam int INHIBIT_CYCLES = 6000;
  localparam int START_CYCLES   = 50;
  localparam int TIMEOUT_CYCLES = 3000;
  localparam int HALF           = 20;
  localparam int SYNC_LAT       = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       sclk_oe, data_oe, tx_ready, busy, tx_done, tx_err;
  wire        sclk_bus, data_bus;

  assign sclk_bus = ~(sclk_oe | dev_clk_low);
  assign data_bus = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT_CYCLES),
    .START_CYCLES   (START_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ps2_sclk    (sclk_bus),
    .i_ps2_data    (data_bus),
    .o_ps2_sclk_oe (sclk_oe),
    .o_ps2_data_oe (data_oe),
    .i_tx_valid    (tx_valid),
    .i_tx_data     (tx_data),
    .o_tx_ready    (tx_ready),
    .o_busy        (busy),
    .o_tx_done     (tx_done),
    .o_tx_err      (tx_err)
  );

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int inh_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sclk_oe && !data_oe) inh_cnt++;
    if (sclk_oe && data_oe)  start_cnt++;
    if (tx_done) done_cnt++;
    if (tx_err)  err_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitReady(input string tag);
    int w = 0;
    while (!tx_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_ready"}, 32'(tx_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  // Device side: clocks n_edges falling edges, samples data at the end of each
  // low phase, and on edge 11 pulls data low when ack is set.
  task automatic runDevice(input bit ack, input int n_edges, input bit inject, output logic [11:0] bits);
    int w = 0;
    bits = '0;
    while (!(!sclk_oe && data_oe) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("clock_release", 32'(w < 20000), 32'd1);
    bits[0] = data_bus;
    for (int k = 1; k <= n_edges; k++) begin
      repeat (HALF - 4) @(negedge clk);
      if (k == ACK_EDGE) dev_data_low = ack;
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      if (inject && k == 3) begin
        tx_valid = 1'b1;
        tx_data  = CMD_RESET;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bits[k] = data_bus;
      dev_clk_low = 1'b0;
    end
    if (n_edges >= ACK_EDGE) begin
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic runFrame(input string tag, input logic [7:0] d, input bit ack, input bit inject,
                          input logic [10:0] exp_frame);
    logic [11:0] bits;
    int inh0, st0, dn0, er0;
    inh0 = inh_cnt; st0 = start_cnt; dn0 = done_cnt; er0 = err_cnt;
    applyStimulus(d);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_not_ready"}, 32'(tx_ready), 32'd0);
    if (inject) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = CMD_RESET;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
    end
    runDevice(ack, ACK_EDGE, inject, bits);
    waitReady(tag);
    checkOutput({tag, "_frame"}, 32'(bits[10:0]), 32'(exp_frame));
    checkOutput({tag, "_inhibit_len"}, 32'(inh_cnt - inh0), 32'(INHIBIT_CYCLES));
    checkOutput({tag, "_start_len"}, 32'(start_cnt - st0), 32'(START_CYCLES));
    checkOutput({tag, "_done_cnt"}, 32'(done_cnt - dn0), ack ? 32'd1 : 32'd0);
    checkOutput({tag, "_err_cnt"}, 32'(err_cnt - er0), ack ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [11:0] bits;
    int w, dn0, er0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sclk_oe", 32'(sclk_oe), 32'd0);
    checkOutput("rst_data_oe", 32'(data_oe), 32'd0);
    checkOutput("rst_done", 32'(tx_done), 32'd0);
    checkOutput("rst_err", 32'(tx_err), 32'd0);
    checkOutput("rst_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Frames as {stop, parity, D7..D0, start}
    runFrame("ed", CMD_SET_LED, 1'b1, 1'b1, 11'h7DA);
    repeat (30) @(negedge clk);
    checkOutput("no_queue_sclk_oe", 32'(sclk_oe), 32'd0);
    checkOutput("no_queue_busy", 32'(busy), 32'd0);

    runFrame("h00", 8'h00, 1'b1, 1'b0, 11'h600);
    runFrame("h01", 8'h01, 1'b1, 1'b0, 11'h402);
    runFrame("nack", CMD_RESET, 1'b0, 1'b0, 11'h7FE);

    // Device stops clocking after edge 4
    dn0 = done_cnt; er0 = err_cnt;
    applyStimulus(CMD_SET_LED);
    runDevice(1'b0, 4, 1'b0, bits);
    w = 0;
    while (!tx_err && w < TIMEOUT_CYCLES + 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("to_delay", 32'(cyc - fall_cyc), 32'(TIMEOUT_CYCLES + SYNC_LAT));
    checkOutput("to_sclk_oe", 32'(sclk_oe), 32'd0);
    checkOutput("to_data_oe", 32'(data_oe), 32'd0);
    checkOutput("to_ready", 32'(tx_ready), 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("to_err_cnt", 32'(err_cnt - er0), 32'd1);
    checkOutput("to_done_cnt", 32'(done_cnt - dn0), 32'd0);

    // Reset while bit D4 (0) is on the bus
    dn0 = done_cnt; er0 = err_cnt;
    applyStimulus(CMD_SET_LED);
    runDevice(1'b1, 5, 1'b0, bits);
    checkOutput("mid_pre_data_oe", 32'(data_oe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_sclk_oe", 32'(sclk_oe), 32'd0);
    checkOutput("mid_data_oe", 32'(data_oe), 32'd0);
    checkOutput("mid_ready", 32'(tx_ready), 32'd1);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("mid_done_cnt", 32'(done_cnt - dn0), 32'd0);
    checkOutput("mid_err_cnt", 32'(err_cnt - er0), 32'd0);
    checkOutput("mid_ready_after", 32'(tx_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
